// File: rtl/final_soc_pio_pkg.sv
// -----------------------------------------------------------------------------
// final_soc_pio_pkg
// Shared constants for the PIO/IRQ block: register address map, edge capture
// mode encoding and the decoded bus request structure.
// -----------------------------------------------------------------------------
package final_soc_pio_pkg;

    // Register address map (3-bit word address)
    localparam logic [2:0] ADDR_DATA    = 3'd0;  // rw: output register
    localparam logic [2:0] ADDR_INPUT   = 3'd1;  // ro: synchronized in_port
    localparam logic [2:0] ADDR_IRQMASK = 3'd2;  // rw: interrupt mask
    localparam logic [2:0] ADDR_EDGECAP = 3'd3;  // r / write-1-to-clear
    localparam logic [2:0] ADDR_OUTSET  = 3'd4;  // wo: set bits of output reg
    localparam logic [2:0] ADDR_OUTCLR  = 3'd5;  // wo: clear bits of output reg

    // Edge capture mode encoding
    localparam int EDGE_RISE = 0;
    localparam int EDGE_FALL = 1;
    localparam int EDGE_ANY  = 2;

    // Decoded slave access for one cycle
    typedef struct packed {
        logic        wr;
        logic        rd;
        logic [2:0]  addr;
        logic [31:0] wdata;
    } pio_req_t;

endpackage

// File: rtl/final_soc_pio_sync.sv
// -----------------------------------------------------------------------------
// final_soc_pio_sync
// WIDTH-bit, STAGES-deep flop synchronizer for asynchronous inputs.
//   clk  : sampling clock
//   rst  : asynchronous active-high reset, clears every stage
//   d_i  : asynchronous input bits
//   q_o  : synchronized output (last stage)
// -----------------------------------------------------------------------------
module final_soc_pio_sync #(
    parameter int WIDTH  = 8,
    parameter int STAGES = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] d_i,
    output logic [WIDTH-1:0] q_o
);

    logic [STAGES-1:0][WIDTH-1:0] sync_q;

    // Stage 0 samples d_i, higher stages shift toward the output
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync_q <= '0;
        end else begin
            sync_q <= {sync_q[STAGES-2:0], d_i};
        end
    end

    assign q_o = sync_q[STAGES-1];

endmodule

// File: rtl/final_soc_pio_irq.sv
// -----------------------------------------------------------------------------
// final_soc_pio_irq
// Memory-mapped parallel I/O port with edge capture and level interrupt.
//   clk, reset          : clock, asynchronous active-high reset
//   address, chipselect : register select / slave select
//   write_n, read_n     : active-low strobes, qualified by chipselect
//   writedata           : write data (bits above WIDTH ignored)
//   readdata            : registered read data (bits above WIDTH zero)
//   in_port             : asynchronous inputs, synchronized then edge-detected
//   out_port            : output register
//   irq                 : OR of captured edges under IRQMASK
// -----------------------------------------------------------------------------
module final_soc_pio_irq
    import final_soc_pio_pkg::*;
#(
    parameter int               WIDTH       = 8,
    parameter logic [WIDTH-1:0] RESET_VALUE = '0,
    parameter int               EDGE_TYPE   = 0,
    parameter int               SYNC_STAGES = 2
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [2:0]       address,
    input  logic             chipselect,
    input  logic             write_n,
    input  logic             read_n,
    input  logic [31:0]      writedata,
    output logic [31:0]      readdata,
    input  logic [WIDTH-1:0] in_port,
    output logic [WIDTH-1:0] out_port,
    output logic             irq
);

    // Edge detection is held off until sync stages and prev register all
    // carry post-reset samples of in_port.
    localparam logic [2:0] PRIME_CYCLES = 3'(SYNC_STAGES + 1);

    pio_req_t         req;
    logic [WIDTH-1:0] wdata;
    logic [WIDTH-1:0] in_sync;
    logic [WIDTH-1:0] prev_q;
    logic [WIDTH-1:0] data_q, data_d;
    logic [WIDTH-1:0] mask_q, mask_d;
    logic [WIDTH-1:0] cap_q, cap_d;
    logic [WIDTH-1:0] raw_edges, edges, clr;
    logic [31:0]      readdata_q, readdata_d;
    logic [2:0]       prime_q, prime_d;
    logic             primed;

    assign req   = '{wr: chipselect & ~write_n, rd: chipselect & ~read_n,
                     addr: address, wdata: writedata};
    assign wdata = req.wdata[WIDTH-1:0];

    if (WIDTH < 32) begin : g_unused_wdata
        logic unused_wdata;
        assign unused_wdata = ^req.wdata[31:WIDTH];
    end

    final_soc_pio_sync #(
        .WIDTH (WIDTH),
        .STAGES(SYNC_STAGES)
    ) u_sync (
        .clk(clk),
        .rst(reset),
        .d_i(in_port),
        .q_o(in_sync)
    );

    assign primed = (prime_q == PRIME_CYCLES);

    always_comb begin
        case (EDGE_TYPE)
            EDGE_FALL: raw_edges = ~in_sync & prev_q;
            EDGE_ANY:  raw_edges = in_sync ^ prev_q;
            default:   raw_edges = in_sync & ~prev_q;
        endcase
        edges = primed ? raw_edges : '0;
    end

    always_comb begin
        data_d     = data_q;
        mask_d     = mask_q;
        readdata_d = readdata_q;
        clr        = '0;
        prime_d    = primed ? prime_q : prime_q + 3'd1;

        // Read mux sees pre-write state, so a simultaneous write does not
        // leak into the returned value.
        if (req.rd) begin
            case (req.addr)
                ADDR_DATA:    readdata_d = 32'(data_q);
                ADDR_INPUT:   readdata_d = 32'(in_sync);
                ADDR_IRQMASK: readdata_d = 32'(mask_q);
                ADDR_EDGECAP: readdata_d = 32'(cap_q);
                default:      readdata_d = '0;
            endcase
        end

        if (req.wr) begin
            case (req.addr)
                ADDR_DATA:    data_d = wdata;
                ADDR_IRQMASK: mask_d = wdata;
                ADDR_EDGECAP: clr    = wdata;
                ADDR_OUTSET:  data_d = data_q | wdata;
                ADDR_OUTCLR:  data_d = data_q & ~wdata;
                default:      ;
            endcase
        end

        // New edges are OR-ed after the clear so a same-cycle capture survives
        cap_d = (cap_q & ~clr) | edges;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            data_q     <= RESET_VALUE;
            mask_q     <= '0;
            cap_q      <= '0;
            readdata_q <= '0;
            prev_q     <= '0;
            prime_q    <= '0;
        end else begin
            data_q     <= data_d;
            mask_q     <= mask_d;
            cap_q      <= cap_d;
            readdata_q <= readdata_d;
            prev_q     <= in_sync;
            prime_q    <= prime_d;
        end
    end

    assign readdata = readdata_q;
    assign out_port = data_q;
    assign irq      = |(cap_q & mask_q);

endmodule

// File: doc/final_soc_pio_irq.md
FINAL_SOC_PIO_IRQ -- requirements
Module: final_soc_pio_irq

Interface
REQ-001 Parameter WIDTH, default 8, port width in bits; legal range 1..32.
REQ-002 Parameter RESET_VALUE, default 0, reset value of the output register (WIDTH bits).
REQ-003 Parameter EDGE_TYPE, default 0, capture mode: 0 rising, 1 falling, 2 any edge.
REQ-004 Parameter SYNC_STAGES, default 2, input synchronizer depth; legal range 2..3.
REQ-005 The block SHALL have one clock and an asynchronous, active-high reset.
REQ-006 Port clk, input, 1, sole clock; all state updates on its rising edge.
REQ-007 Port reset, input, 1, asynchronous active-high reset.
REQ-008 Port address, input, 3, register select.
REQ-009 Port chipselect, input, 1, slave select.
REQ-010 Port write_n, input, 1, active-low write strobe; qualified by chipselect.
REQ-011 Port read_n, input, 1, active-low read strobe; qualified by chipselect.
REQ-012 Port writedata, input, 32, write data; bits above WIDTH are ignored.
REQ-013 Port readdata, output, 32, registered read data; bits above WIDTH always zero.
REQ-014 Port in_port, input, WIDTH, asynchronous external inputs.
REQ-015 Port out_port, output, WIDTH, output register contents.
REQ-016 Port irq, output, 1, level interrupt, active high.

Function
REQ-017 Address map: 0 DATA (rw, output register), 1 INPUT (ro, synchronized in_port), 2 IRQMASK (rw), 3 EDGECAP (read; write-1-to-clear), 4 OUTSET (wo), 5 OUTCLR (wo); addresses 6-7 read 0, writes ignored.
REQ-018 Write to DATA: output register <= writedata[WIDTH-1:0] on the write edge; out_port reflects it the same cycle after the edge.
REQ-019 Write to OUTSET: output register <= reg | writedata; OUTCLR: reg <= reg & ~writedata; zero bits leave the register unchanged.
REQ-020 Read: readdata registered, valid on the edge following the cycle where chipselect and ~read_n are asserted; held otherwise; OUTSET/OUTCLR read as 0.
REQ-021 Simultaneous read and write strobes: write takes effect; readdata returns the pre-write value.
REQ-022 in_port passes SYNC_STAGES flops, then a one-flop previous-value register; edge detection compares the last sync stage with the previous-value register per EDGE_TYPE.
REQ-023 A detected edge sets its EDGECAP bit; with SYNC_STAGES=2 a change on in_port stable before edge k sets EDGECAP at edge k+2.
REQ-024 EDGECAP bits stay set until cleared by a write of 1; a write of 0 has no effect.
REQ-025 Same-cycle edge detection and write-1-to-clear on one bit: set wins, bit remains 1.
REQ-026 irq = OR of (EDGECAP & IRQMASK), driven from registered state, no added latency.
REQ-027 Priming: a counter SHALL suppress edge detection until the synchronizer and previous-value register hold valid samples (SYNC_STAGES+1 cycles after reset deassertion), so a static level present at reset never causes a capture.

Reset
REQ-028 While reset is high: output register = RESET_VALUE, IRQMASK = 0, EDGECAP = 0, readdata = 0, synchronizer and previous-value flops = 0, priming counter = 0, irq = 0.
REQ-029 Reset asserted mid-operation clears all state immediately, independent of clk; pending captures are lost.

Structure
REQ-030 Package final_soc_pio_pkg SHALL hold the register address constants and the edge-type encoding constants.
REQ-031 Sub-module final_soc_pio_sync: parametrised WIDTH x SYNC_STAGES synchronizer with asynchronous active-high reset; instantiated once.

Verification
REQ-032 Reset with RESET_VALUE=8'hA5 -> out_port=8'hA5, irq=0, readdata=0; read IRQMASK -> 0.
REQ-033 Write DATA 8'h0F, OUTSET 8'hF0, OUTCLR 8'h03 -> out_port 8'h0F, 8'hFF, 8'hFC after each write; read DATA returns 8'hFC one cycle after the read strobe.
REQ-034 EDGE_TYPE=0, IRQMASK=8'h01, in_port bit0 0->1 -> EDGECAP=8'h01 two edges later, irq=1; write EDGECAP 8'h01 -> irq=0 next cycle.
REQ-035 in_port=8'hFF held through reset deassertion -> EDGECAP stays 0 for 20 cycles; then bit3 1->0 with EDGE_TYPE=1 -> EDGECAP=8'h08.
REQ-036 Clear of bit0 timed on the same edge as a new bit0 capture -> EDGECAP bit0 stays 1, irq stays 1.
REQ-037 Reset pulse mid-capture with irq=1 -> irq=0 and EDGECAP=0 asynchronously, out_port=RESET_VALUE.
